// File: rtl/ysyx_lsu_mem_resp_pkg.sv
// Shared types and constants for the LSU memory responder: FSM encoding, strobe codes, LFSR step.
package ysyx_lsu_mem_resp_pkg;

  typedef enum logic [1:0] {
    MRESP_IDLE    = 2'd0,
    MRESP_RD_WAIT = 2'd1,
    MRESP_WR_WAIT = 2'd2,
    MRESP_DONE    = 2'd3
  } mresp_state_e;

  localparam logic [7:0] STRB_B = 8'h1;
  localparam logic [7:0] STRB_H = 8'h3;
  localparam logic [7:0] STRB_W = 8'hf;

  localparam logic [7:0] LFSR_SEED = 8'h5A;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/ysyx_lsu_mem_resp_if.sv
// LSU load/store bus between the LSU (master) and the memory responder (slave).
interface ysyx_lsu_mem_resp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Requests are levels: the LSU holds arvalid (or awvalid+wvalid) with stable
  // address/data until the matching one-cycle rvalid_o / wready_o pulse; the
  // responder ignores further requests until every valid has dropped once.
  logic [ADDR_W-1:0] lsu_araddr;
  logic              lsu_arvalid;
  logic [7:0]        lsu_rstrb;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              lsu_rvalid_o;
  logic [ADDR_W-1:0] lsu_awaddr;
  logic              lsu_awvalid;
  logic [DATA_W-1:0] lsu_wdata;
  logic [7:0]        lsu_wstrb;
  logic              lsu_wvalid;
  logic              lsu_wready_o;

  modport master (
    output lsu_araddr, lsu_arvalid, lsu_rstrb,
    output lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    input  lsu_rdata_o, lsu_rvalid_o, lsu_wready_o
  );

  modport slave (
    input  lsu_araddr, lsu_arvalid, lsu_rstrb,
    input  lsu_awaddr, lsu_awvalid, lsu_wdata, lsu_wstrb, lsu_wvalid,
    output lsu_rdata_o, lsu_rvalid_o, lsu_wready_o
  );
endinterface

// File: rtl/ysyx_lsu_mem_resp_lfsr8.sv
// 8-bit free-running LFSR used to jitter the memory response delay.
module ysyx_lfsr8
  import ysyx_lsu_mem_resp_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/ysyx_lsu_mem_resp.sv
// Memory-side responder for the LSU bus, answering from an internal word array after a set latency.
// Optional feature: define YSYX_MEM_RAND_DELAY_EN to add 0..7 pseudo-random wait cycles per request.
module ysyx_lsu_mem_resp
  import ysyx_lsu_mem_resp_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int                LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_lsu_mem_resp_if.slave  bus,
  output logic                busy_o,
  output mresp_state_e        dbg_state
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = 9;

  mresp_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  delay;
  logic              wr_acc, rd_acc, rd_resp, wr_resp;

  logic [MEM_AW-1:0] rd_idx_q;
  logic              rd_in_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q, wready_q;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Word index relative to BASE_ADDR; addresses below the base wrap high and fall out of range.
  logic [ADDR_W-1:0] rd_rel, wr_rel;
  logic              rd_in, wr_in;
  logic [MEM_AW-1:0] wr_idx;
  logic [1:0]        wr_off;
  logic [NB-1:0]     wmask;
  logic [DATA_W-1:0] wdata_sh;

  assign rd_rel   = bus.lsu_araddr - BASE_ADDR;
  assign wr_rel   = bus.lsu_awaddr - BASE_ADDR;
  assign rd_in    = (rd_rel[ADDR_W-1:MEM_AW+2] == '0);
  assign wr_in    = (wr_rel[ADDR_W-1:MEM_AW+2] == '0);
  assign wr_idx   = wr_rel[MEM_AW+1:2];
  assign wr_off   = bus.lsu_awaddr[1:0];
  assign wmask    = bus.lsu_wstrb[NB-1:0] << wr_off;
  assign wdata_sh = bus.lsu_wdata << {wr_off, 3'b000};

`ifdef YSYX_MEM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  ysyx_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign delay       = CNT_W'(LATENCY) + CNT_W'(lfsr_q[2:0]);
  assign unused_lfsr = ^lfsr_q[7:3];
`else
  assign delay = CNT_W'(LATENCY);
`endif

  // rstrb only describes access width, which cannot change the word index of an aligned access.
  logic unused_bits;
  assign unused_bits = ^{rd_rel[1:0], wr_rel[1:0], bus.lsu_wstrb[7:NB], bus.lsu_rstrb};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    rd_resp = 1'b0;
    wr_resp = 1'b0;
    case (state_q)
      MRESP_IDLE: begin
        if (bus.lsu_awvalid && bus.lsu_wvalid) begin
          wr_acc  = 1'b1;
          cnt_d   = delay;
          state_d = MRESP_WR_WAIT;
        end else if (bus.lsu_arvalid) begin
          rd_acc  = 1'b1;
          cnt_d   = delay;
          state_d = MRESP_RD_WAIT;
        end
      end
      MRESP_RD_WAIT: begin
        if (cnt_q == '0) begin
          rd_resp = 1'b1;
          state_d = MRESP_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MRESP_WR_WAIT: begin
        if (cnt_q == '0) begin
          wr_resp = 1'b1;
          state_d = MRESP_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MRESP_DONE: begin
        // A still-held request must not be taken a second time.
        if (!bus.lsu_arvalid && !bus.lsu_awvalid && !bus.lsu_wvalid)
          state_d = MRESP_IDLE;
      end
      default: state_d = MRESP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MRESP_IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      wready_q <= 1'b0;
      rdata_q  <= '0;
      rd_idx_q <= '0;
      rd_in_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_resp;
      wready_q <= wr_resp;
      if (rd_acc) begin
        rd_idx_q <= rd_rel[MEM_AW+1:2];
        rd_in_q  <= rd_in;
      end
      if (rd_resp)
        rdata_q <= rd_in_q ? mem[rd_idx_q] : '0;
    end
  end

  // The array has no reset; a write commits on its accept edge so later reads see it.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc && wr_in) begin
      for (int b = 0; b < NB; b++)
        if (wmask[b]) mem[wr_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
    end
  end

  assign bus.lsu_rdata_o  = rdata_q;
  assign bus.lsu_rvalid_o = rvalid_q;
  assign bus.lsu_wready_o = wready_q;
  assign busy_o           = (state_q != MRESP_IDLE);
  assign dbg_state        = state_q;

endmodule
